// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - round-robin N-to-1 valid/ready stream mux with registered, source-tagged output
module rr_stream_mux #(
  parameter int N = 2,
  parameter int W = 8,
  localparam int IW = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_src,
  input  logic           out_ready
);

  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic [IW-1:0]  r_out_src;
  logic [N-1:0]   r_prio;

  logic           w_load_en;
  logic [N-1:0]   w_masked;
  logic [N-1:0]   w_sel;
  logic [N-1:0]   w_grant;
  logic [IW-1:0]  w_grant_idx;
  logic [N-1:0]   w_next_prio;
  logic           w_found;
  logic [W-1:0]   w_grant_data;
  logic           w_xfer;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_masked  = in_valid & r_prio;

  // Lowest requester above the last winner first, then wrap to the lowest requester overall.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_next_prio = '0;
    w_found     = 1'b0;
    w_sel       = (|w_masked) ? w_masked : in_valid;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_sel[i]) begin
        w_grant[i]  = 1'b1;
        w_grant_idx = IW'(i);
        w_found     = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      w_next_prio[j] = (j > int'(w_grant_idx));
    end
  end

  assign w_grant_data = in_data[int'(w_grant_idx)*W +: W];
  assign in_ready     = rst ? '0 : (w_grant & {N{w_load_en}});
  assign w_xfer       = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_prio      <= '1;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_src   <= w_grant_idx;
        r_prio      <= w_next_prio;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - scoreboard bench for rr_stream_mux at N=2/W=8 and N=4/W=16
module tb_rr_stream_mux;

  logic        clk;
  int          checks;
  int          failures;

  logic        rst2;
  logic [1:0]  in_valid2;
  logic [15:0] in_data2;
  logic [1:0]  in_ready2;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [0:0]  out_src2;
  logic        out_ready2;
  logic [8:0]  q2[$];
  int          pops2;

  logic        rst4;
  logic [3:0]  in_valid4;
  logic [63:0] in_data4;
  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [15:0] out_data4;
  logic [1:0]  out_src4;
  logic        out_ready4;
  logic [17:0] q4[$];
  int          pops4;

  rr_stream_mux #(.N(2), .W(8)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_src(out_src2), .out_ready(out_ready2)
  );

  rr_stream_mux #(.N(4), .W(16)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4), .out_ready(out_ready4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle on the N=2 instance: drive, check ready, pop any accepted output, push any accepted input.
  task automatic step2(input logic [1:0] v, input logic [15:0] d, input logic ordy,
                       input logic [1:0] exp_rdy, input string name);
    logic [8:0] got;
    logic [8:0] exp;
    in_valid2 = v; in_data2 = d; out_ready2 = ordy;
    @(negedge clk);
    checks++;
    if (in_ready2 !== exp_rdy) begin
      failures++;
      $display("FAIL %s in_ready got=%b exp=%b", name, in_ready2, exp_rdy);
    end
    if (out_valid2 === 1'b1 && ordy) begin
      got = {out_src2, out_data2};
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected_output got=%h exp=none", name, got);
      end else begin
        exp = q2.pop_front();
        pops2++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s out_word got=%h exp=%h", name, got, exp);
        end
      end
    end
    for (int i = 0; i < 2; i++)
      if (exp_rdy[i]) q2.push_back({1'(i), d[i*8 +: 8]});
    @(posedge clk); #1;
  endtask

  task automatic step4(input logic [3:0] v, input logic [63:0] d, input logic ordy,
                       input logic [3:0] exp_rdy, input string name);
    logic [17:0] got;
    logic [17:0] exp;
    in_valid4 = v; in_data4 = d; out_ready4 = ordy;
    @(negedge clk);
    checks++;
    if (in_ready4 !== exp_rdy) begin
      failures++;
      $display("FAIL %s in_ready got=%b exp=%b", name, in_ready4, exp_rdy);
    end
    if (out_valid4 === 1'b1 && ordy) begin
      got = {out_src4, out_data4};
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected_output got=%h exp=none", name, got);
      end else begin
        exp = q4.pop_front();
        pops4++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s out_word got=%h exp=%h", name, got, exp);
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) q4.push_back({2'(i), d[i*16 +: 16]});
    @(posedge clk); #1;
  endtask

  task automatic reset2();
    rst2 = 1'b1; in_valid2 = '0; out_ready2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    q2.delete();
  endtask

  task automatic drain2(input string name);
    step2(2'b00, 16'h0, 1'b1, 2'b00, name);
    checks++;
    if (q2.size() != 0 || out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL %s drain left=%0d out_valid=%b exp=0/0", name, q2.size(), out_valid2);
    end
  endtask

  task automatic test_reset();
    in_valid2 = 2'b11; in_data2 = 16'h3CA5; out_ready2 = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready2 !== 2'b00 || out_valid2 !== 1'b0 || out_data2 !== 8'h00 || out_src2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_state rdy=%b v=%b d=%h s=%b exp=00/0/00/0",
                 in_ready2, out_valid2, out_data2, out_src2);
      end
      @(posedge clk); #1;
    end
    rst2 = 1'b0;
    q2.delete();
    step2(2'b11, 16'h3CA5, 1'b1, 2'b01, "reset_first_grant");
    drain2("reset_drain");
  endtask

  task automatic test_alternation();
    logic [1:0] vseq[10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    logic [1:0] rseq[10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    reset2();
    for (int k = 0; k < 10; k++)
      step2(vseq[k], 16'($urandom), 1'b1, rseq[k], $sformatf("alt%0d", k));
    drain2("alt_drain");
  endtask

  task automatic test_stall();
    reset2();
    step2(2'b11, 16'h3CA5, 1'b1, 2'b01, "stall_load");
    for (int k = 0; k < 3; k++) begin
      step2(2'b11, 16'h3CA5, 1'b0, 2'b00, $sformatf("stall%0d", k));
      checks++;
      if (out_valid2 !== 1'b1 || out_data2 !== 8'hA5 || out_src2 !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d v=%b d=%h s=%b exp=1/a5/0", k, out_valid2, out_data2, out_src2);
      end
    end
    step2(2'b11, 16'h3CA5, 1'b1, 2'b10, "stall_release");
    checks++;
    if (out_data2 !== 8'h3C || out_src2 !== 1'b1) begin
      failures++;
      $display("FAIL stall_next d=%h s=%b exp=3c/1", out_data2, out_src2);
    end
    drain2("stall_drain");
  endtask

  task automatic test_idle_no_rotate();
    reset2();
    step2(2'b01, 16'h0011, 1'b1, 2'b01, "idle_first");
    for (int k = 0; k < 3; k++)
      step2(2'b00, 16'h0, 1'b1, 2'b00, $sformatf("idle%0d", k));
    step2(2'b11, 16'h2233, 1'b1, 2'b10, "idle_then_grant");
    drain2("idle_drain");
  endtask

  task automatic test_reset_midstream();
    reset2();
    step2(2'b11, 16'h7755, 1'b1, 2'b01, "mid_load");
    step2(2'b00, 16'h0, 1'b0, 2'b00, "mid_stall");
    rst2 = 1'b1;
    step2(2'b11, 16'h7755, 1'b0, 2'b00, "mid_rst_cycle");
    rst2 = 1'b0;
    q2.delete();
    checks++;
    if (out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL mid_discard out_valid=%b exp=0", out_valid2);
    end
    step2(2'b11, 16'h9988, 1'b1, 2'b01, "mid_regrant");
    drain2("mid_drain");
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic [15:0] base;
    rst4 = 1'b1; in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    q4.delete();
    pops4 = 0;
    base = 16'h1000;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) d[i*16 +: 16] = base + 16'(k*4 + i);
      step4(4'b1111, d, 1'b1, 4'(1 << (k % 4)), $sformatf("b2b%0d", k));
      checks++;
      if (out_valid4 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_bubble%0d out_valid=%b exp=1", k, out_valid4);
      end
    end
    step4(4'b0000, 64'h0, 1'b1, 4'b0000, "b2b_drain");
    checks++;
    if (pops4 != 12 || q4.size() != 0) begin
      failures++;
      $display("FAIL b2b_count words=%0d left=%0d exp=12/0", pops4, q4.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time_limit got=expired exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; pops2 = 0; pops4 = 0;
    rst2 = 1'b1; in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b1;
    rst4 = 1'b1; in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    test_reset();
    test_alternation();
    test_stall();
    test_idle_no_rotate();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
